// File: rtl/fft_frame_sched.sv
// Frame scheduler for the 4-lane fft_64 data FIFO bank. It issues the shared ctrl_in start pulse,
// exports the beat phase, predicts output framing and checks lane-0 ctrl_out against it.
module fft_frame_sched #(
  parameter int unsigned FRAME_LEN    = 16,
  parameter int unsigned PHASE_W      = 4,
  parameter int unsigned FIFO_LAT     = 16,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sop,
  output logic               in_ready,
  output logic               fifo_ctrl,
  output logic [PHASE_W-1:0] fifo_phase,
  input  logic               fifo_ctrl_out,
  output logic               out_sop,
  output logic               out_valid,
  output logic [1:0]         inflight,
  output logic               gap_err,
  output logic               sop_err,
  output logic               align_err,
  input  logic               err_clr
);

  localparam logic [PHASE_W-1:0] LAST_PH = PHASE_W'(FRAME_LEN - 1);
  localparam logic [1:0]         MAX_F   = 2'(MAX_INFLIGHT);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_ERR} state_e;

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [FIFO_LAT-1:0] dly_q, dly_d;
  logic [PHASE_W-1:0]  ocnt_q, ocnt_d;
  logic [1:0]          infl_q, infl_d;
  logic                gap_q, gap_d;
  logic                sop_q, sop_d;
  logic                align_q, align_d;
  logic                armed_q, armed_d;

  logic                room;
  logic                start;
  logic                ready_c;
  logic                ctrl_c;
  logic                gap_set;
  logic                sop_set;
  logic                align_set;
  logic                last_beat;
  logic [PHASE_W-1:0]  phase_out;

  assign room  = (infl_q < MAX_F);
  assign start = in_valid & in_sop & room;

  // Phase 0 in STREAM is the slot right after a frame's last beat: either a back-to-back
  // start is taken there or the scheduler falls back to IDLE, so it behaves like IDLE.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    phase_out = phase_q;
    ready_c   = 1'b0;
    ctrl_c    = 1'b0;
    gap_set   = 1'b0;
    sop_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = room;
        if (start) begin
          ctrl_c    = 1'b1;
          phase_out = '0;
          phase_d   = PHASE_W'(1);
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (phase_q == '0) begin
          ready_c = room;
          if (start) begin
            ctrl_c  = 1'b1;
            phase_d = PHASE_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ready_c = 1'b1;
          if (in_valid) begin
            sop_set = in_sop;
            phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PHASE_W'(1);
          end else begin
            gap_set = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        if (err_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready   = rst & ready_c;
  assign fifo_ctrl  = rst & ctrl_c;
  assign fifo_phase = phase_out;

  assign out_sop   = dly_q[FIFO_LAT-1];
  assign out_valid = out_sop | (ocnt_q != '0);
  assign last_beat = ~out_sop & (ocnt_q == PHASE_W'(1));

  always_comb begin
    dly_d  = {dly_q[FIFO_LAT-2:0], fifo_ctrl};
    ocnt_d = ocnt_q;
    if (out_sop)              ocnt_d = LAST_PH;
    else if (ocnt_q != '0)    ocnt_d = ocnt_q - PHASE_W'(1);

    infl_d = infl_q;
    case ({fifo_ctrl, last_beat})
      2'b10:   if (infl_q < MAX_F) infl_d = infl_q + 2'd1;
      2'b01:   if (infl_q != '0)   infl_d = infl_q - 2'd1;
      default: infl_d = infl_q;
    endcase
  end

  // The out_sop cycle itself is the first one checked after reset or err_clr.
  always_comb begin
    align_set = (armed_q | out_sop) & (fifo_ctrl_out != out_sop);
    armed_d   = err_clr ? 1'b0 : (armed_q | out_sop);
    gap_d     = gap_set   | (gap_q   & ~err_clr);
    sop_d     = sop_set   | (sop_q   & ~err_clr);
    align_d   = align_set | (align_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      dly_q   <= '0;
      ocnt_q  <= '0;
      infl_q  <= '0;
      gap_q   <= 1'b0;
      sop_q   <= 1'b0;
      align_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dly_q   <= dly_d;
      ocnt_q  <= ocnt_d;
      infl_q  <= infl_d;
      gap_q   <= gap_d;
      sop_q   <= sop_d;
      align_q <= align_d;
      armed_q <= armed_d;
    end
  end

  assign inflight  = infl_q;
  assign gap_err   = gap_q;
  assign sop_err   = sop_q;
  assign align_err = align_q;

endmodule
